// File: rtl/bch_poly_decoder.sv
// bch_poly_decoder: bit-serial decoder for codewords c(x) = m(x)*g(x).
// Divides the received word by g(x) to recover the message (quotient).
// A non-zero remainder starts a single-error search, a bit flip and a
// second division. Returns the message with syndrome and status flags.
//
// Optional feature macro: BCH_DEC_STATS_EN
//   defined   -> saturating 16-bit counters of corrected / uncorrectable
//                words, counted on each output handshake
//   undefined -> stat_corrected / stat_uncorrectable are tied to zero
//
// state  | meaning
// IDLE   | ready for a new codeword
// DIVIDE | shift one codeword bit per cycle through the remainder LFSR
// CHECK  | inspect remainder / illegal high bits after a division
// SEARCH | walk x^idx mod g looking for the syndrome of a single error
// DONE   | result held on the outputs until the consumer accepts it
module bch_poly_decoder #(
  parameter int MSG_W = 8,
  parameter int GEN_W = 6,
  parameter logic [GEN_W-1:0] GEN_POLY = 6'b100101,
  parameter int CW_BUS_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW_BUS_W-1:0] in_codeword,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MSG_W-1:0]    out_msg,
  output logic [GEN_W-2:0]    out_syndrome,
  output logic                out_corrected,
  output logic [3:0]          out_err_pos,
  output logic                out_uncorrectable,
  output logic [15:0]         stat_corrected,
  output logic [15:0]         stat_uncorrectable
);

  localparam int R = GEN_W - 1;
  localparam int N = MSG_W + GEN_W - 1;
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [R-1:0] GEN_LOW = GEN_POLY[R-1:0];

  typedef enum logic [2:0] {IDLE, DIVIDE, CHECK, SEARCH, DONE} state_t;

  state_t state, state_next;

  logic [CW_BUS_W-1:0] cw_reg;
  logic [R-1:0]        rem;
  logic [R-1:0]        syn;
  logic [R-1:0]        s_reg;
  logic [MSG_W-1:0]    quo;
  logic [MSG_W-1:0]    quo_first;
  logic [3:0]          cnt;
  logic [3:0]          idx;
  logic [3:0]          err_pos;
  logic                second_pass;
  logic                corrected;
  logic                uncorr;

  logic                high_bit;
  logic                rem_zero;
  logic                match;
  logic [R-1:0]        rem_step;
  logic [R-1:0]        s_step;

  // Decode helpers: illegal high bits, LFSR division step, next x^i mod g
  always_comb begin
    high_bit = |(cw_reg >> N);
    rem_zero = (rem == '0);
    match    = (s_reg == rem);
    rem_step = {rem[R-2:0], cw_reg[cnt]} ^ (rem[R-1] ? GEN_LOW : '0);
    s_step   = {s_reg[R-2:0], 1'b0} ^ (s_reg[R-1] ? GEN_LOW : '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (in_valid) state_next = DIVIDE;
      DIVIDE: if (cnt == 4'd0) state_next = CHECK;
      CHECK: begin
        if (high_bit || rem_zero || second_pass) state_next = DONE;
        else                                     state_next = SEARCH;
      end
      SEARCH: begin
        if (match)             state_next = DIVIDE;
        else if (idx == LAST)  state_next = DONE;
      end
      DONE:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: codeword, division registers, search and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_reg      <= '0;
      rem         <= '0;
      syn         <= '0;
      s_reg       <= '0;
      quo         <= '0;
      quo_first   <= '0;
      cnt         <= '0;
      idx         <= '0;
      err_pos     <= '0;
      second_pass <= 1'b0;
      corrected   <= 1'b0;
      uncorr      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cw_reg      <= in_codeword;
            rem         <= '0;
            syn         <= '0;
            quo         <= '0;
            quo_first   <= '0;
            cnt         <= LAST;
            err_pos     <= '0;
            second_pass <= 1'b0;
            corrected   <= 1'b0;
            uncorr      <= 1'b0;
          end
        end
        DIVIDE: begin
          rem <= rem_step;
          quo <= {quo[MSG_W-2:0], rem[R-1]};
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        CHECK: begin
          if (!second_pass) begin
            syn       <= rem;
            quo_first <= quo;
          end
          if (high_bit || (!rem_zero && second_pass)) begin
            uncorr <= 1'b1;
          end else if (!rem_zero) begin
            s_reg <= {{(R-1){1'b0}}, 1'b1};
            idx   <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            cw_reg[idx] <= ~cw_reg[idx];
            corrected   <= 1'b1;
            err_pos     <= idx;
            cnt         <= LAST;
            rem         <= '0;
            quo         <= '0;
            second_pass <= 1'b1;
          end else if (idx == LAST) begin
            uncorr <= 1'b1;
          end else begin
            s_reg <= s_step;
            idx   <= idx + 4'd1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // An uncorrectable word reports the quotient of the received bits
  always_comb begin
    in_ready          = (state == IDLE);
    out_valid         = (state == DONE);
    out_msg           = uncorr ? quo_first : quo;
    out_syndrome      = syn;
    out_corrected     = corrected;
    out_err_pos       = err_pos;
    out_uncorrectable = uncorr;
  end

`ifdef BCH_DEC_STATS_EN
  logic handshake;
  assign handshake = (state == DONE) && out_ready;

  // Saturating word counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_corrected     <= '0;
      stat_uncorrectable <= '0;
    end else if (handshake) begin
      if (corrected && stat_corrected != 16'hFFFF)
        stat_corrected <= stat_corrected + 16'd1;
      if (uncorr && stat_uncorrectable != 16'hFFFF)
        stat_uncorrectable <= stat_uncorrectable + 16'd1;
    end
  end
`else
  assign stat_corrected     = '0;
  assign stat_uncorrectable = '0;
`endif

endmodule

// File: tb/tb_bch_poly_decoder.sv
// tb_bch_poly_decoder: table vectors, a polynomial-arithmetic reference
// model for random words, and hand sequences for stall and reset.
module tb_bch_poly_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_codeword = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_msg;
  logic [4:0]  out_syndrome;
  logic        out_corrected;
  logic [3:0]  out_err_pos;
  logic        out_uncorrectable;
  logic [15:0] stat_corrected;
  logic [15:0] stat_uncorrectable;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bch_poly_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_err_pos(out_err_pos),
    .out_uncorrectable(out_uncorrectable),
    .stat_corrected(stat_corrected), .stat_uncorrectable(stat_uncorrectable)
  );

  typedef struct {
    logic [13:0] cw;
    int msg;
    int syn;
    int corr;
    int pos;
    int unc;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic over GF(2) polynomials, g = x^5+x^2+1
  function automatic int pmod(input int a);
    int r = a;
    for (int b = 12; b >= 5; b--)
      if (r[b]) r = r ^ (32'h25 << (b - 5));
    return r & 32'h1f;
  endfunction

  function automatic int pdiv(input int a);
    int r = a;
    int q = 0;
    for (int b = 12; b >= 5; b--)
      if (r[b]) begin
        r = r ^ (32'h25 << (b - 5));
        q = q | (1 << (b - 5));
      end
    return q;
  endfunction

  function automatic int clmul(input int m);
    int r = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r = r ^ (32'h25 << i);
    return r;
  endfunction

  function automatic vec_t model(input logic [13:0] cw);
    vec_t v;
    int low = int'(cw[12:0]);
    v.cw = cw; v.corr = 0; v.pos = 0; v.unc = 0;
    v.syn = pmod(low);
    v.msg = pdiv(low);
    if (cw[13]) begin
      v.unc = 1; v.lat = 15;
    end else if (v.syn == 0) begin
      v.lat = 15;
    end else begin
      v.unc = 1; v.lat = 28;
      for (int i = 0; i < 13; i++)
        if (v.unc == 1 && pmod(1 << i) == v.syn) begin
          v.unc = 0; v.corr = 1; v.pos = i; v.lat = 30 + i;
          v.msg = pdiv(low ^ (1 << i));
        end
    end
    return v;
  endfunction

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send(input logic [13:0] cw, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_codeword = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t e, input int lat);
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " msg"}, int'(out_msg), e.msg);
    chk({tag, " syndrome"}, int'(out_syndrome), e.syn);
    chk({tag, " corrected"}, int'(out_corrected), e.corr);
    chk({tag, " err_pos"}, int'(out_err_pos), e.pos);
    chk({tag, " uncorrectable"}, int'(out_uncorrectable), e.unc);
  endtask

  vec_t tbl[7];
  vec_t e;
  int lat;
  int hi_cnt;
  logic [13:0] cw;
  int m;

  initial begin
    tbl[0] = '{14'h1742, 8'hAA, 5'h00, 0, 0,  0, 15};
    tbl[1] = '{14'h1752, 8'hAA, 5'h10, 1, 4,  0, 34};
    tbl[2] = '{14'h1741, 8'hAA, 5'h03, 0, 0,  1, 28};
    tbl[3] = '{14'h3742, 8'hAA, 5'h00, 0, 0,  1, 15};
    tbl[4] = '{14'h1743, 8'hAA, 5'h01, 1, 0,  0, 30};
    tbl[5] = '{14'h0742, 8'hAA, 5'h0E, 1, 12, 0, 42};
    tbl[6] = '{14'h1CE3, 8'hFF, 5'h00, 0, 0,  0, 15};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_msg", int'(out_msg), 0);
    chk("reset stat_corrected", int'(stat_corrected), 0);
    chk("reset stat_uncorrectable", int'(stat_uncorrectable), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].cw, lat);
      check_vec($sformatf("vec%0d", i), tbl[i], lat);
      handshake();
    end

    for (int i = 0; i < 60; i++) begin
      m = int'($urandom_range(0, 255));
      cw = 14'(clmul(m));
      case ($urandom_range(0, 5))
        0: ;
        1, 2: cw[$urandom_range(0, 12)] ^= 1'b1;
        3, 4: begin
          cw[$urandom_range(0, 6)] ^= 1'b1;
          cw[$urandom_range(7, 12)] ^= 1'b1;
        end
        default: cw[13] = 1'b1;
      endcase
      e = model(cw);
      send(cw, lat);
      check_vec($sformatf("rand%0d cw=%0h", i, cw), e, lat);
      handshake();
    end

    // Stall in DONE with a second word already offered
    send(14'h1742, lat);
    chk("stall first latency", lat, 15);
    @(negedge clk);
    in_valid = 1'b1;
    in_codeword = 14'h1752;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall out_valid", int'(out_valid), 1);
      chk("stall out_msg", int'(out_msg), 8'hAA);
      chk("stall in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after handshake out_valid", int'(out_valid), 0);
    chk("after handshake in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second word accepted", int'(in_ready), 0);
    wait_result(lat);
    check_vec("stall second", tbl[1], lat);
    handshake();

    // Reset in the middle of a division
    @(negedge clk);
    in_valid = 1'b1;
    in_codeword = 14'h1752;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset in_ready", int'(in_ready), 1);
    chk("midreset out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) hi_cnt++;
    end
    chk("midreset no output", hi_cnt, 0);

    send(14'h1752, lat);
    check_vec("stats word2", tbl[1], lat);
    handshake();
    send(14'h1741, lat);
    check_vec("stats word3", tbl[2], lat);
    handshake();
`ifdef BCH_DEC_STATS_EN
    chk("stat_corrected", int'(stat_corrected), 1);
    chk("stat_uncorrectable", int'(stat_uncorrectable), 1);
`else
    chk("stat_corrected tied", int'(stat_corrected), 0);
    chk("stat_uncorrectable tied", int'(stat_uncorrectable), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
